mul_add_seq: RTL and testbench

- Sequential shift-add multiply-accumulate computing p = q*b + r.
- Inverse of the pipelined restoring divider: feeding its quotient, divisor and remainder back reconstructs the dividend.
- Used in the tracker datapath for centroid/scale back-projection and as a self-check partner for division results.
- Area-lean, multi-cycle, valid/ready on both sides.

---
 rtl/mul_add_seq.sv | 74 +++++++
 tb/tb_mul_add_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mul_add_seq.sv
// mul_add_seq: multi-cycle shift-add multiply-accumulate, p = q*b + r, valid/ready on both sides.
// Define MUL_ADD_RADIX4_EN to retire two bits of q per clock (latency ceil(MUL_W/2) instead of MUL_W).
module mul_add_seq #(
    parameter int MUL_W = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MUL_W-1:0]   q,
    input  logic [MUL_W-1:0]   b,
    input  logic [MUL_W-1:0]   r,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*MUL_W-1:0] p
);
`ifdef MUL_ADD_RADIX4_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int ITER = (MUL_W + STEP - 1) / STEP;
    localparam int CW   = $clog2(ITER + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state, state_n;
    logic [MUL_W-1:0]   qs;
    logic [2*MUL_W-1:0] bs, acc, addend, sum;
    logic [CW-1:0]      cnt;
    logic               last;
    // q shifts right and b shifts left each step, so no barrel shifter is needed
`ifdef MUL_ADD_RADIX4_EN
    always_comb addend = (qs[0] ? bs : '0) + (qs[1] ? (bs << 1) : '0);
`else
    always_comb addend = qs[0] ? bs : '0;
`endif
    always_comb begin
        sum       = acc + addend;
        last      = cnt == CW'(ITER - 1);
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        state_n   = state;
        if (state == IDLE && in_valid)
            state_n = BUSY;
        else if (state == BUSY && last)
            state_n = DONE;
        else if (state == DONE && out_ready)
            state_n = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            qs    <= '0;
            bs    <= '0;
            acc   <= '0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                qs  <= q;
                bs  <= {{MUL_W{1'b0}}, b};
                acc <= {{MUL_W{1'b0}}, r};
                cnt <= '0;
            end else if (state == BUSY) begin
                qs  <= qs >> STEP;
                bs  <= bs << STEP;
                acc <= sum;
                cnt <= cnt + 1'b1;
                if (last)
                    p <= sum;
            end
        end
    end
endmodule

// File: tb/tb_mul_add_seq.sv
// tb_mul_add_seq: table-driven vectors, backpressure/reset sequences and a divider round-trip
// checked through an expected-result queue.
module tb_mul_add_seq;
    localparam int W = 30;
`ifdef MUL_ADD_RADIX4_EN
    localparam int LAT = 15;
`else
    localparam int LAT = 30;
`endif
    logic           clk = 0, rst_n = 1, in_valid = 0, out_ready = 1;
    logic           in_ready, out_valid;
    logic [W-1:0]   q = '0, b = '0, r = '0;
    logic [2*W-1:0] p;
    int             n_cmp = 0, n_bad = 0;
    logic [63:0]    sb[$];

    typedef struct {
        logic [W-1:0] q, b, r;
        logic [63:0]  e;
    } vec_t;
    vec_t vecs[8];

    mul_add_seq #(.MUL_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .q(q), .b(b), .r(r), .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one full transaction with out_ready held high; expected result supplied by caller
    task automatic run(input logic [W-1:0] qi, bi, ri, input logic [63:0] e);
        int n;
        bit busy_ok;
        logic [63:0] x;
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 1);
        in_valid = 1; q = qi; b = bi; r = ri;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 0; q = W'($urandom); b = W'($urandom); r = W'($urandom);
        n = 0; busy_ok = 1;
        while (!out_valid && n < 100) begin
            busy_ok &= !in_ready;
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(LAT));
        chk("busy_in_ready_low", 64'(busy_ok && !in_ready), 1);
        x = sb.pop_front();
        chk("p", 64'(p), x);
        @(posedge clk); #1;
        chk("out_valid_after_hs", 64'(out_valid), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] a, lim;
        logic [W-1:0] dq, dr, rb;
        int n;
        bit hold_ok;
        vecs[0] = '{30'd5, 30'd7, 30'd3, 64'd38};
        vecs[1] = '{30'h3FFFFFFF, 30'h3FFFFFFF, 30'h3FFFFFFF, 64'h0FFF_FFFF_C000_0000};
        vecs[2] = '{30'd123, 30'd0, 30'd9, 64'd9};
        vecs[3] = '{30'd0, 30'd77, 30'd0, 64'd0};
        vecs[4] = '{30'd1, 30'h3FFFFFFF, 30'd0, 64'h3FFFFFFF};
        vecs[5] = '{30'h20000000, 30'd2, 30'd1, 64'h40000001};
        vecs[6] = '{30'd1000, 30'd1000, 30'd999, 64'd1000999};
        vecs[7] = '{30'h3FFFFFFF, 30'd1, 30'h3FFFFFFF, 64'h7FFFFFFE};
        #1 rst_n = 0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_p", 64'(p), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        foreach (vecs[i]) run(vecs[i].q, vecs[i].b, vecs[i].r, vecs[i].e);

        // backpressure: result held while inputs toggle
        out_ready = 0;
        @(negedge clk);
        in_valid = 1; q = 30'd21; b = 30'd2; r = 30'd4;
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("bp_latency", 64'(n), 64'(LAT));
        chk("bp_p", 64'(p), 64'd46);
        hold_ok = 1;
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'($urandom); q = W'($urandom); b = W'($urandom); r = W'($urandom);
            @(posedge clk); #1;
            hold_ok &= out_valid && !in_ready && p == 60'd46;
        end
        chk("bp_hold", 64'(hold_ok), 1);
        @(negedge clk);
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        chk("bp_out_valid_drop", 64'(out_valid), 0);
        chk("bp_in_ready_back", 64'(in_ready), 1);
        chk("bp_p_kept", 64'(p), 64'd46);

        // asynchronous reset in the middle of BUSY
        @(negedge clk);
        in_valid = 1; q = 30'd7; b = 30'd9; r = 30'd1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (15) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 0);
        chk("mid_rst_p", 64'(p), 0);
        chk("mid_rst_in_ready", 64'(in_ready), 1);
        @(negedge clk);
        rst_n = 1;
        run(30'd11, 30'd13, 30'd2, 64'd145);

        // divider round-trip: a = (a/b)*b + a%b
        for (int k = 0; k < 1000; k++) begin
            rb  = W'($urandom_range(1, 32'h3FFFFFFF));
            lim = 64'(rb) << W;
            a   = {$urandom, $urandom} % lim;
            dq  = W'(a / 64'(rb));
            dr  = W'(a % 64'(rb));
            run(dq, rb, dr, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
